drac_tile_reset_sequencer: RTL and testbench

// Reset/wake-up sequencer for a multi-hart Sargantana tile in OpenPiton.
// - Generalises the single-core wake-up counter and registered global-reset follower to NumHarts cores.
// - Adds staggered per-hart reset release, per-hart enable masking and queued per-hart soft resets.
// - Sits between the tile reset and each core's RST/SOFT_RST inputs.
//

---
 rtl/drac_tile_reset_sequencer_if.sv | 33 +++
 rtl/drac_tile_reset_sequencer.sv | 174 +++++++++++++++++
 tb/tb_drac_tile_reset_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/drac_tile_reset_sequencer_if.sv
// rtl/drac_tile_reset_sequencer_if.sv - per-hart control/status bundle of the tile reset sequencer
// soft_rst_cnt_o is present only when DRAC_RSTSEQ_SOFTCNT_EN is defined.
interface drac_tile_reset_sequencer_if #(
    parameter int NumHarts = 4
);
    logic [NumHarts-1:0] hart_en_i;
    logic [NumHarts-1:0] soft_rst_req_i;
    logic [NumHarts-1:0] hart_rst_no;
    logic                grst_o;
    logic                all_up_o;
    logic                busy_o;
`ifdef DRAC_RSTSEQ_SOFTCNT_EN
    logic [16*NumHarts-1:0] soft_rst_cnt_o;

    modport master (
        output hart_en_i, soft_rst_req_i,
        input  hart_rst_no, grst_o, all_up_o, busy_o, soft_rst_cnt_o
    );
    modport slave (
        input  hart_en_i, soft_rst_req_i,
        output hart_rst_no, grst_o, all_up_o, busy_o, soft_rst_cnt_o
    );
`else
    modport master (
        output hart_en_i, soft_rst_req_i,
        input  hart_rst_no, grst_o, all_up_o, busy_o
    );
    modport slave (
        input  hart_en_i, soft_rst_req_i,
        output hart_rst_no, grst_o, all_up_o, busy_o
    );
`endif
endinterface

// File: rtl/drac_tile_reset_sequencer.sv
// rtl/drac_tile_reset_sequencer.sv - staggered multi-hart reset release with queued soft resets
// Optional per-hart soft-reset counters: DRAC_RSTSEQ_SOFTCNT_EN.
module drac_tile_reset_sequencer #(
    parameter int NumHarts      = 4,
    parameter int WakeUpCycles  = 32768,
    parameter int StaggerCycles = 16,
    parameter int SoftRstCycles = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    drac_tile_reset_sequencer_if.slave         seq_bus
);
    localparam int MaxWs  = (WakeUpCycles > StaggerCycles) ? WakeUpCycles : StaggerCycles;
    localparam int MaxCyc = (MaxWs > SoftRstCycles) ? MaxWs : SoftRstCycles;
    localparam int CW     = $clog2(MaxCyc + 1);
    localparam int IW     = (NumHarts > 1) ? $clog2(NumHarts) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAKE    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [NumHarts-1:0] r_hart_rst_n;
    logic [NumHarts-1:0] r_pending;
    logic [NumHarts-1:0] r_en_q;
    logic                r_active;
    logic [IW-1:0]       r_act_idx;
    logic                r_grst;
    logic                r_all_up;
    logic                r_busy;

    logic [NumHarts-1:0] w_en;
    logic [NumHarts-1:0] w_avail;
    logic [NumHarts-1:0] w_sel_mask;
    logic [NumHarts-1:0] w_pend_nxt;
    logic                w_sel_valid;
    logic [IW-1:0]       w_sel_idx;
    logic                w_act_done;
    logic                w_act_nxt;
    logic                w_dec_go;
    logic [IW-1:0]       w_dec_idx;
    logic                w_dec_last;

    assign w_en = seq_bus.hart_en_i;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_sel_mask  = '0;
        w_avail     = r_pending & w_en;
        // Descending scan so the lowest pending index is the one left selected.
        if (r_state == ST_RUN && !r_active) begin
            for (int i = NumHarts - 1; i >= 0; i--) begin
                if (w_avail[i]) begin
                    w_sel_valid = 1'b1;
                    w_sel_idx   = IW'(i);
                end
            end
        end
        if (w_sel_valid) begin
            w_sel_mask[w_sel_idx] = 1'b1;
        end
        w_act_done = r_active && w_en[r_act_idx] && (r_cnt == '0);
        w_act_nxt  = w_sel_valid || (r_active && w_en[r_act_idx] && (r_cnt != '0));
        // A request landing on the selection cycle survives the clear and re-queues the hart.
        w_pend_nxt = ((r_pending & ~w_sel_mask) | seq_bus.soft_rst_req_i | (w_en & ~r_en_q)) & w_en;
        w_dec_go   = ((r_state == ST_WAKE) && (r_cnt == CW'(WakeUpCycles - 1))) ||
                     ((r_state == ST_RELEASE) && (r_cnt == '0));
        w_dec_idx  = (r_state == ST_WAKE) ? '0 : r_idx;
        w_dec_last = (w_dec_idx == IW'(NumHarts - 1));
    end

`ifdef DRAC_RSTSEQ_SOFTCNT_EN
    logic [15:0] r_soft_cnt [NumHarts];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumHarts; i++) begin
                r_soft_cnt[i] <= '0;
            end
        end else if (w_sel_valid && (r_soft_cnt[w_sel_idx] != 16'hFFFF)) begin
            r_soft_cnt[w_sel_idx] <= r_soft_cnt[w_sel_idx] + 16'd1;
        end
    end

    for (genvar g = 0; g < NumHarts; g++) begin : g_cnt_out
        assign seq_bus.soft_rst_cnt_o[16*g +: 16] = r_soft_cnt[g];
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_hart_rst_n <= '0;
            r_pending    <= '0;
            r_en_q       <= '0;
            r_active     <= 1'b0;
            r_act_idx    <= '0;
            r_grst       <= 1'b0;
            r_all_up     <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_grst       <= 1'b1;
            r_en_q       <= w_en;
            // Any released hart drops out as soon as its enable goes low, in every state.
            r_hart_rst_n <= r_hart_rst_n & w_en;

            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_WAKE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
                ST_WAKE: begin
                    if (r_cnt != CW'(WakeUpCycles - 1)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    r_pending <= w_pend_nxt;
                    r_active  <= w_act_nxt;
                    r_busy    <= w_act_nxt | (|w_pend_nxt);
                    if (w_sel_valid) begin
                        r_act_idx               <= w_sel_idx;
                        r_cnt                   <= CW'(SoftRstCycles - 1);
                        r_hart_rst_n[w_sel_idx] <= 1'b0;
                    end else if (r_active && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    if (w_act_done) begin
                        r_hart_rst_n[r_act_idx] <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Release decision: the wake-up terminal edge doubles as the decision for hart 0.
            if (w_dec_go) begin
                if (w_en[w_dec_idx]) begin
                    r_hart_rst_n[w_dec_idx] <= 1'b1;
                    r_cnt                   <= CW'(StaggerCycles - 1);
                end else begin
                    r_cnt <= '0;
                end
                if (w_dec_last) begin
                    r_state  <= ST_RUN;
                    r_all_up <= 1'b1;
                    r_busy   <= 1'b0;
                end else begin
                    r_state <= ST_RELEASE;
                    r_idx   <= w_dec_idx + 1'b1;
                end
            end
        end
    end

    assign seq_bus.hart_rst_no = r_hart_rst_n;
    assign seq_bus.grst_o      = r_grst;
    assign seq_bus.all_up_o    = r_all_up;
    assign seq_bus.busy_o      = r_busy;

endmodule

// File: tb/tb_drac_tile_reset_sequencer.sv
// tb/tb_drac_tile_reset_sequencer.sv - self-checking bench for drac_tile_reset_sequencer
module tb_drac_tile_reset_sequencer;
    localparam int NH = 4;
    localparam int W  = 8;
    localparam int S  = 4;
    localparam int SR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    drac_tile_reset_sequencer_if #(.NumHarts(NH)) seq_bus();

    drac_tile_reset_sequencer #(
        .NumHarts(NH), .WakeUpCycles(W), .StaggerCycles(S), .SoftRstCycles(SR)
    ) u_dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .seq_bus(seq_bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [NH-1:0] exp_q[$];
    int m_rel[NH];
    int m_last;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release time of each hart and of the last decision, measured in edges after E0.
    task automatic model_release(input logic [NH-1:0] en);
        int t;
        t = W;
        for (int k = 0; k < NH; k++) begin
            m_rel[k] = -1;
            m_last   = t;
            if (en[k]) begin
                m_rel[k] = t;
                t += S;
            end else begin
                t += 1;
            end
        end
    endtask

    task automatic boot_and_check(input logic [NH-1:0] en, input string tag);
        logic [NH-1:0] e;
        rst = 1'b1;
        seq_bus.hart_en_i = en;
        seq_bus.soft_rst_req_i = '0;
        step();
        step();
        checks++; if (seq_bus.hart_rst_no !== '0) begin failures++; $display("FAIL %s rst hart_rst_no got=%b exp=0000", tag, seq_bus.hart_rst_no); end
        checks++; if (seq_bus.busy_o !== 1'b1) begin failures++; $display("FAIL %s rst busy got=%b exp=1", tag, seq_bus.busy_o); end
        rst = 1'b0;
        model_release(en);
        for (int n = 0; n <= m_last + 2; n++) begin
            e = '0;
            for (int k = 0; k < NH; k++) e[k] = (m_rel[k] >= 0) && (n >= m_rel[k]);
            exp_q.push_back(e);
        end
        for (int n = 0; n <= m_last + 2; n++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if (seq_bus.hart_rst_no !== e) begin
                failures++;
                $display("FAIL %s hart_rst_no n=%0d got=%b exp=%b", tag, n, seq_bus.hart_rst_no, e);
            end
            checks++;
            if (seq_bus.all_up_o !== (n >= m_last)) begin
                failures++;
                $display("FAIL %s all_up n=%0d got=%b exp=%b", tag, n, seq_bus.all_up_o, n >= m_last);
            end
            if (n == 0) begin
                checks++;
                if (seq_bus.grst_o !== 1'b1) begin failures++; $display("FAIL %s grst n=0 got=%b exp=1", tag, seq_bus.grst_o); end
            end
        end
        checks++; if (seq_bus.busy_o !== 1'b0) begin failures++; $display("FAIL %s busy idle got=%b exp=0", tag, seq_bus.busy_o); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        seq_bus.hart_en_i = '1;
        seq_bus.soft_rst_req_i = '0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (seq_bus.hart_rst_no !== '0) begin failures++; $display("FAIL reset hart_rst_no got=%b exp=0000", seq_bus.hart_rst_no); end
        checks++; if (seq_bus.grst_o !== 1'b0) begin failures++; $display("FAIL reset grst got=%b exp=0", seq_bus.grst_o); end
        checks++; if (seq_bus.all_up_o !== 1'b0) begin failures++; $display("FAIL reset all_up got=%b exp=0", seq_bus.all_up_o); end
        checks++; if (seq_bus.busy_o !== 1'b1) begin failures++; $display("FAIL reset busy got=%b exp=1", seq_bus.busy_o); end
    endtask

    task automatic test_cold_boot();
        boot_and_check(4'b1111, "cold");
    endtask

    task automatic test_soft_simul();
        logic [NH-1:0] e;
        for (int n = 1; n <= 11; n++) begin
            e = 4'b1111;
            if (n >= 2 && n <= 4) e[1] = 1'b0;
            if (n >= 6 && n <= 8) e[3] = 1'b0;
            exp_q.push_back(e);
        end
        for (int n = 1; n <= 11; n++) begin
            seq_bus.soft_rst_req_i = (n == 1) ? 4'b1010 : 4'b0000;
            step();
            e = exp_q.pop_front();
            checks++;
            if (seq_bus.hart_rst_no !== e) begin failures++; $display("FAIL simul hart_rst_no n=%0d got=%b exp=%b", n, seq_bus.hart_rst_no, e); end
            checks++;
            if (seq_bus.busy_o !== (n <= 8)) begin failures++; $display("FAIL simul busy n=%0d got=%b exp=%b", n, seq_bus.busy_o, n <= 8); end
        end
        seq_bus.soft_rst_req_i = '0;
    endtask

    task automatic test_rerequest(input int second_at);
        logic [NH-1:0] e;
        for (int n = 1; n <= 10; n++) begin
            e = 4'b1111;
            if ((n >= 2 && n <= 4) || (n >= 6 && n <= 8)) e[0] = 1'b0;
            exp_q.push_back(e);
        end
        for (int n = 1; n <= 10; n++) begin
            seq_bus.soft_rst_req_i = (n == 1 || n == second_at) ? 4'b0001 : 4'b0000;
            step();
            e = exp_q.pop_front();
            checks++;
            if (seq_bus.hart_rst_no !== e) begin failures++; $display("FAIL rereq%0d hart_rst_no n=%0d got=%b exp=%b", second_at, n, seq_bus.hart_rst_no, e); end
        end
        seq_bus.soft_rst_req_i = '0;
        checks++; if (seq_bus.busy_o !== 1'b0) begin failures++; $display("FAIL rereq%0d busy got=%b exp=0", second_at, seq_bus.busy_o); end
    endtask

    task automatic test_enable_toggle();
        logic [NH-1:0] e;
        logic exp_busy;
        for (int n = 1; n <= 10; n++) begin
            e = 4'b1111;
            if (n <= 7) e[2] = 1'b0;
            exp_q.push_back(e);
        end
        for (int n = 1; n <= 10; n++) begin
            seq_bus.hart_en_i = (n <= 3) ? 4'b1011 : 4'b1111;
            step();
            e = exp_q.pop_front();
            exp_busy = (n >= 4 && n <= 7);
            checks++;
            if (seq_bus.hart_rst_no !== e) begin failures++; $display("FAIL entoggle hart_rst_no n=%0d got=%b exp=%b", n, seq_bus.hart_rst_no, e); end
            checks++;
            if (seq_bus.busy_o !== exp_busy) begin failures++; $display("FAIL entoggle busy n=%0d got=%b exp=%b", n, seq_bus.busy_o, exp_busy); end
        end
    endtask

    task automatic test_masked();
        boot_and_check(4'b1011, "masked");
        for (int n = 1; n <= 6; n++) begin
            seq_bus.soft_rst_req_i = (n == 1) ? 4'b0100 : 4'b0000;
            step();
            checks++;
            if (seq_bus.hart_rst_no !== 4'b1011) begin failures++; $display("FAIL masked_req hart_rst_no n=%0d got=%b exp=1011", n, seq_bus.hart_rst_no); end
            checks++;
            if (seq_bus.busy_o !== 1'b0) begin failures++; $display("FAIL masked_req busy n=%0d got=%b exp=0", n, seq_bus.busy_o); end
        end
        seq_bus.soft_rst_req_i = '0;
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        seq_bus.hart_en_i = 4'b1111;
        step();
        step();
        rst = 1'b0;
        for (int n = 0; n <= 13; n++) begin
            step();
            if (n == 12) begin
                checks++;
                if (seq_bus.hart_rst_no !== 4'b0011) begin failures++; $display("FAIL midrst pre hart_rst_no got=%b exp=0011", seq_bus.hart_rst_no); end
            end
        end
        rst = 1'b1;
        step();
        checks++; if (seq_bus.hart_rst_no !== '0) begin failures++; $display("FAIL midrst hart_rst_no got=%b exp=0000", seq_bus.hart_rst_no); end
        checks++; if (seq_bus.grst_o !== 1'b0) begin failures++; $display("FAIL midrst grst got=%b exp=0", seq_bus.grst_o); end
        checks++; if (seq_bus.all_up_o !== 1'b0) begin failures++; $display("FAIL midrst all_up got=%b exp=0", seq_bus.all_up_o); end
        checks++; if (seq_bus.busy_o !== 1'b1) begin failures++; $display("FAIL midrst busy got=%b exp=1", seq_bus.busy_o); end
        boot_and_check(4'b1111, "reboot");
    endtask

`ifdef DRAC_RSTSEQ_SOFTCNT_EN
    task automatic test_softcnt();
        boot_and_check(4'b1111, "cntboot");
        checks++;
        if (seq_bus.soft_rst_cnt_o !== 64'h0) begin failures++; $display("FAIL softcnt clear got=%h exp=0", seq_bus.soft_rst_cnt_o); end
        for (int r = 0; r < 3; r++) begin
            seq_bus.soft_rst_req_i = 4'b0010;
            step();
            seq_bus.soft_rst_req_i = '0;
            for (int i = 0; i < 6; i++) step();
        end
        checks++;
        if (seq_bus.soft_rst_cnt_o !== 64'h0000_0000_0003_0000) begin
            failures++;
            $display("FAIL softcnt got=%h exp=0000000000030000", seq_bus.soft_rst_cnt_o);
        end
    endtask
`endif

    initial begin
        seq_bus.hart_en_i = '1;
        seq_bus.soft_rst_req_i = '0;
        test_reset();
        test_cold_boot();
        test_soft_simul();
        test_rerequest(2);
        test_rerequest(3);
        test_enable_toggle();
        test_masked();
        test_mid_reset();
`ifdef DRAC_RSTSEQ_SOFTCNT_EN
        test_softcnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
